// File: rtl/tt_um_priority_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_priority_decoder
// Description : Registered index-to-one-hot decoder. Takes the 8-bit result
//               code of a 16-input priority encoder (0..15 = index of the
//               highest set input, 0xF0 = no input set, anything else is
//               illegal) and rebuilds the 16-bit one-hot vector. The vector
//               is shown one byte at a time on uo_out. Status flags go out
//               on uio_out[7:4].
//
//               Optional feature macro: PRIORITY_DECODER_ACCUM_EN
//                 defined   : a sticky 16-bit mask ORs successive decodes.
//                             uio_in[3] selects mask or one-hot for display.
//                             uio_out[7] reports a full mask.
//                 undefined : no mask register is built. uio_in[3] is
//                             ignored and uio_out[7] is tied to 0.
//
// Ports       : clk      in   clock, rising edge
//               rst_n    in   synchronous active-low reset
//               ena      in   power-good, ignored
//               ui_in    in   [7:0] code byte from the encoder
//               uio_in   in   [0] valid, [1] clear, [2] byte select,
//                             [3] display mode, [7:4] unused
//               uo_out   out  selected byte of the displayed vector
//               uio_out  out  [3:0] 0, [4] none, [5] error, [6] vld_out,
//                             [7] mask full
//               uio_oe   out  constant 8'hF0 (upper nibble driven)
//
// Revision    : 1.0  initial release
// ============================================================================
module tt_um_priority_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [7:0] C_CODE_NONE = 8'hF0;
  localparam logic [7:0] C_OE_MASK   = 8'hF0;

  // --------------------------------------------------------------------------
  // Control field extraction
  // --------------------------------------------------------------------------
  logic w_valid;
  logic w_clear;
  logic w_sel;
  logic w_mode;

  assign w_valid = uio_in[0];
  assign w_clear = uio_in[1];
  assign w_sel   = uio_in[2];
  assign w_mode  = uio_in[3];

  // --------------------------------------------------------------------------
  // Code classification
  // A legal index has a zero upper nibble. The "none" code and the
  // illegal codes both decode to an all-zero vector.
  // --------------------------------------------------------------------------
  logic        w_legal;
  logic        w_none;
  logic        w_illegal;
  logic [15:0] w_decode;

  always_comb begin
    w_legal   = (ui_in[7:4] == 4'h0);
    w_none    = (ui_in == C_CODE_NONE);
    w_illegal = !w_legal && !w_none;
    w_decode  = 16'h0000;
    if (w_legal) begin
      w_decode[ui_in[3:0]] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Capture registers: one-hot result, flags and output strobe
  // --------------------------------------------------------------------------
  logic [15:0] onehot_q, onehot_d;
  logic        none_q,   none_d;
  logic        err_q,    err_d;
  logic        vld_q,    vld_d;

  // A valid capture wins over clear. Clear only zeroes the held result
  // when no new code arrives in the same cycle.
  always_comb begin
    onehot_d = onehot_q;
    none_d   = none_q;
    err_d    = err_q;
    vld_d    = 1'b0;
    if (w_valid) begin
      onehot_d = w_decode;
      none_d   = w_none;
      err_d    = w_illegal;
      vld_d    = 1'b1;
    end else if (w_clear) begin
      onehot_d = 16'h0000;
      none_d   = 1'b0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      onehot_q <= 16'h0000;
      none_q   <= 1'b0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      onehot_q <= onehot_d;
      none_q   <= none_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional accumulation mask and display selection
  // --------------------------------------------------------------------------
  logic [15:0] w_display;
  logic        w_mask_full;
  logic        w_unused;

`ifdef PRIORITY_DECODER_ACCUM_EN
  logic [15:0] mask_q, mask_d;

  // Clear acts before the OR, so clear+valid leaves just the new decode.
  // None and illegal codes decode to zero and so leave the mask alone.
  always_comb begin
    mask_d = (w_clear ? 16'h0000 : mask_q) | (w_valid ? w_decode : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= 16'h0000;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign w_display   = w_mode ? mask_q : onehot_q;
  assign w_mask_full = (mask_q == 16'hFFFF);
  assign w_unused    = &{1'b0, ena, uio_in[7:4]};
`else
  assign w_display   = onehot_q;
  assign w_mask_full = 1'b0;
  assign w_unused    = &{1'b0, ena, uio_in[7:4], w_mode};
`endif

  // --------------------------------------------------------------------------
  // Outputs: byte select and mode are combinational, no added latency
  // --------------------------------------------------------------------------
  assign uo_out  = w_sel ? w_display[15:8] : w_display[7:0];
  assign uio_out = {w_mask_full, vld_q, err_q, none_q, 4'b0000};
  assign uio_oe  = C_OE_MASK;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_priority_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_priority_decoder
// Description : Self-checking bench for tt_um_priority_decoder. A vector
//               table covers single-cycle decode behaviour. Hand-written
//               sequences cover reset, clear, mode and accumulation.
//               Accumulation checks build when PRIORITY_DECODER_ACCUM_EN
//               is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tt_um_priority_decoder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests;
  int n_fail;

  tt_um_priority_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       valid;
    logic       clear;
    logic       sel;
    logic [7:0] code;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Set control pins: valid, clear, sel, mode.
  task automatic drive(input logic v, input logic c, input logic s, input logic m,
                       input logic [7:0] code);
    uio_in = {4'b0000, m, s, c, v};
    ui_in  = code;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ena     = 1'b1;
    rst_n   = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h05);

    // uio_out = {full, vld, err, none, 4'b0}
    vecs[0]  = '{"lo05",      1'b1, 1'b0, 1'b0, 8'h05, 8'h20, 8'h40};
    vecs[1]  = '{"hold05",    1'b0, 1'b0, 1'b0, 8'h05, 8'h20, 8'h00};
    vecs[2]  = '{"hold05_hi", 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 8'h00};
    vecs[3]  = '{"hi0C",      1'b1, 1'b0, 1'b1, 8'h0C, 8'h10, 8'h40};
    vecs[4]  = '{"b2b0C_lo",  1'b1, 1'b0, 1'b0, 8'h0C, 8'h00, 8'h40};
    vecs[5]  = '{"noneF0",    1'b1, 1'b0, 1'b0, 8'hF0, 8'h00, 8'h50};
    vecs[6]  = '{"noneHold",  1'b0, 1'b0, 1'b1, 8'hF0, 8'h00, 8'h10};
    vecs[7]  = '{"ill33",     1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 8'h60};
    vecs[8]  = '{"lo07",      1'b1, 1'b0, 1'b0, 8'h07, 8'h80, 8'h40};
    vecs[9]  = '{"clr",       1'b0, 1'b1, 1'b0, 8'h07, 8'h00, 8'h00};
    vecs[10] = '{"clrVld0F",  1'b1, 1'b1, 1'b1, 8'h0F, 8'h80, 8'h40};
    vecs[11] = '{"ill10",     1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 8'h60};
    vecs[12] = '{"lo00",      1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h40};
    vecs[13] = '{"illFF",     1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h60};

    // Reset held two cycles with valid and code 0x05 present.
    for (int i = 0; i < 2; i++) begin
      step();
      uio_in[2] = 1'b0;
      #1;
      check("rst_uo_lo", uo_out, 8'h00);
      uio_in[2] = 1'b1;
      #1;
      check("rst_uo_hi", uo_out, 8'h00);
      check("rst_uio", uio_out, 8'h00);
      check("rst_oe", uio_oe, 8'hF0);
      uio_in[2] = 1'b0;
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    step();
    check("post_rst_uio", uio_out, 8'h00);

    // Table-driven single-cycle vectors
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].valid, vecs[i].clear, vecs[i].sel, 1'b0, vecs[i].code);
      step();
      check({vecs[i].name, "_uo"}, uo_out, vecs[i].exp_uo);
      check({vecs[i].name, "_uio"}, uio_out, vecs[i].exp_uio);
    end

    // Mid-stream reset discards the captured result.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h09);
    step();
    check("pre_mrst_uo", uo_out, 8'h02);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h05);
    step();
    check("mrst_uio", uio_out, 8'h00);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step();
    check("mrst_uo_hi", uo_out, 8'h00);
    uio_in[2] = 1'b0;
    #1;
    check("mrst_uo_lo", uo_out, 8'h00);
    check("mrst_uio2", uio_out, 8'h00);

    // Clear without valid after code 0x07 with a flag raised first.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    check("clr07_uo", uo_out, 8'h00);
    check("clr07_uio", uio_out, 8'h00);

`ifdef PRIORITY_DECODER_ACCUM_EN
    // Codes 0, 3, 15 accumulate into the mask.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h0F);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    #1;
    check("acc_lo", uo_out, 8'h09);
    uio_in[2] = 1'b1;
    #1;
    check("acc_hi", uo_out, 8'h80);
    uio_in[3] = 1'b0;
    #1;
    check("acc_onehot_hi", uo_out, 8'h80);
    uio_in[2] = 1'b0;
    #1;
    check("acc_onehot_lo", uo_out, 8'h00);

    // Clear together with valid leaves just the new decode.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h02);
    step();
    check("clrv_lo", uo_out, 8'h04);
    uio_in[2] = 1'b1;
    #1;
    check("clrv_hi", uo_out, 8'h00);

    // All sixteen codes, then an illegal code: mask stays full.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'(k));
      step();
    end
    check("full_uio", uio_out, 8'hC0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
    step();
    check("fullAA_uio", uio_out, 8'hE0);
    check("fullAA_lo", uo_out, 8'hFF);
    uio_in[2] = 1'b1;
    #1;
    check("fullAA_hi", uo_out, 8'hFF);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    step();
    check("fullclr_uo", uo_out, 8'h00);
    check("fullclr_uio", uio_out, 8'h00);
`else
    // Mode input is ignored: display stays one-hot.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    #1;
    check("mode_ign_lo", uo_out, 8'h04);
    check("mode_ign_uio", uio_out, 8'h40);
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'(k));
      step();
    end
    check("nofull_uio", uio_out, 8'h40);
    uio_in[2] = 1'b1;
    #1;
    check("nofull_hi", uo_out, 8'h80);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tt_um_priority_decoder.md
# tt_um_priority_decoder

Registered index-to-one-hot decoder: the receive-side counterpart of the team's 16-input priority encoder. It consumes the encoder's 8-bit result code (0–15 = index of the highest set input, 0xF0 = no input set) under a valid strobe and rebuilds a 16-bit one-hot vector. The vector is presented one byte at a time on the dedicated outputs, with status flags on the upper bidirectional pins. An optional accumulation register ORs successive decodes into a sticky 16-bit mask.

## Interface
Parameters:
- none; the design is fixed at 16 lanes / 8-bit code.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  always 1 when powered; ignored.
- ui_in  in  8  code byte from the encoder.
- uio_in  in  8  [0] valid, [1] clear, [2] byte select (0 = bits 7:0, 1 = bits 15:8), [3] display mode (0 = one-hot, 1 = accumulated mask), [7:4] unused.
- uo_out  out  8  selected byte of the displayed 16-bit vector.
- uio_out  out  8  [3:0] = 0, [4] none flag, [5] error flag, [6] vld_out, [7] mask full.
- uio_oe  out  8  constant 8'hF0.

## Operation
- Code classification:
  - 0x00–0x0F: legal index; decode = 1 << code.
  - 0xF0: none; decode = 0.
  - Any other value: illegal; decode = 0.
- Registers: onehot[15:0], none_f, err_f, vld_out, mask[15:0] (mask only when ACCUM_EN is defined).
- When valid = 1 at a clock edge:
  - onehot is loaded with the decode.
  - none_f is set to (code == 0xF0).
  - err_f is set to (code is illegal).
  - vld_out is set to 1.
- When valid = 0 at a clock edge: onehot, none_f and err_f hold; vld_out clears to 0.
- Mask update: mask <= (clear ? 0 : mask) | (valid ? decode : 0).
  - clear together with valid leaves mask equal to the new decode alone.
  - An illegal or none code leaves mask unchanged, or zero if clear is also set.
- Clear = 1 without valid: onehot, none_f, err_f and mask all go to 0. Clear has no effect on onehot or the flags when valid is also 1.
- Display vector = (mode && ACCUM_EN) ? mask : onehot.
- uo_out = sel ? display[15:8] : display[7:0].
- uio_out[7] = (mask == 16'hFFFF); it is 0 when ACCUM_EN is not defined.
- Reset (rst_n = 0 at an edge) clears onehot, mask, none_f, err_f and vld_out to 0. Reset has priority over valid and clear. A reset asserted mid-stream discards the captured state.

## Timing
- Decode latency is 1 cycle: a code presented with valid at edge N appears on uo_out after edge N.
- vld_out is high for exactly the cycle following each valid edge. Back-to-back valid cycles hold vld_out high continuously.
- sel and mode are combinational to uo_out with no added latency. The host may toggle sel between two cycles to read both bytes of the same result.
- Reset values: uo_out = 0x00, uio_out = 0x00, uio_oe = 0xF0, throughout and after reset.
- No backpressure: every valid cycle is accepted.

## Configuration
- Macro: PRIORITY_DECODER_ACCUM_EN.
- Defined:
  - The mask register and mask-full flag are implemented.
  - uio_in[3] selects the displayed vector.
- Undefined:
  - No mask register is built.
  - uio_in[3] is ignored and the display is always onehot.
  - uio_out[7] is tied to 0.
  - clear still zeroes onehot and the flags.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with valid = 1 and code 0x05 → uo_out = 0x00, uio_out = 0x00, uio_oe = 0xF0.
- Low-byte decode: code 0x05 with valid for one cycle, sel = 0 → next cycle uo_out = 0x20 and uio_out[6] = 1; the following cycle uio_out[6] = 0 and uo_out holds 0x20; with sel = 1 → 0x00.
- High-byte decode: code 0x0C with valid, sel = 1 → uo_out = 0x10.
- Special codes:
  - code 0xF0 → uo_out = 0x00 for both sel values, uio_out[4] = 1, uio_out[5] = 0.
  - code 0x33 → uo_out = 0x00, uio_out[5] = 1, uio_out[4] = 0.
- Accumulation (ACCUM_EN defined):
  - codes 0, 3, 15 on consecutive valid cycles, mode = 1 → sel = 0 reads 0x09, sel = 1 reads 0x80.
  - clear + valid with code 2 → mask reads 0x0004.
  - all 16 codes, then code 0xAA → uio_out[7] = 1 and mask stays 0xFFFF.
- Clear without valid, after code 0x07 → uo_out = 0x00 and all flags = 0 on the next cycle.
